// File: rtl/sata_cont_generator_pkg.sv
// Shared SATA primitive encodings, TX dword payload type and the repeatable-primitive test.
package sata_cont_generator_pkg;

    localparam int unsigned DWORD_W = 32;
    localparam int unsigned LFSR_W  = 16;

    localparam logic [LFSR_W-1:0]  LFSR_SEED     = 16'hFFFF;

    localparam logic [DWORD_W-1:0] PRIM_ALIGN    = 32'h7B4A_4ABC;
    localparam logic [DWORD_W-1:0] PRIM_CONT     = 32'h9999_AA7C;
    localparam logic [DWORD_W-1:0] PRIM_SYNC     = 32'hB5B5_957C;
    localparam logic [DWORD_W-1:0] PRIM_X_RDY    = 32'h5757_B57C;
    localparam logic [DWORD_W-1:0] PRIM_R_RDY    = 32'h4A4A_957C;
    localparam logic [DWORD_W-1:0] PRIM_R_IP     = 32'h5555_B57C;
    localparam logic [DWORD_W-1:0] PRIM_R_OK     = 32'h3535_B57C;
    localparam logic [DWORD_W-1:0] PRIM_R_ERR    = 32'h5656_B57C;
    localparam logic [DWORD_W-1:0] PRIM_WTRM     = 32'h5858_B57C;
    localparam logic [DWORD_W-1:0] PRIM_HOLD     = 32'hD5D5_AA7C;
    localparam logic [DWORD_W-1:0] PRIM_HOLDA    = 32'h9595_AA7C;
    localparam logic [DWORD_W-1:0] PRIM_PMREQ_P  = 32'h1717_B57C;
    localparam logic [DWORD_W-1:0] PRIM_PMREQ_S  = 32'h7575_957C;
    localparam logic [DWORD_W-1:0] PRIM_SOF      = 32'h3737_B57C;
    localparam logic [DWORD_W-1:0] PRIM_EOF      = 32'hD5D5_B57C;

    typedef struct packed {
        logic [DWORD_W-1:0] data;
        logic               is_k;
    } sata_dword_t;

    // True for primitives that may be collapsed into CONT + junk.
    function automatic logic prim_is_repeatable(input logic [DWORD_W-1:0] d, input logic is_k);
        logic r;
        r = 1'b0;
        if (is_k) begin
            case (d)
                PRIM_SYNC, PRIM_X_RDY, PRIM_R_RDY, PRIM_R_IP, PRIM_R_OK, PRIM_R_ERR,
                PRIM_WTRM, PRIM_HOLD, PRIM_HOLDA, PRIM_PMREQ_P, PRIM_PMREQ_S: r = 1'b1;
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/sata_cont_generator_scrambler.sv
// Junk-dword source: 16-bit LFSR (x^16+x^15+x^13+x^4+1) advanced 32 bits per enabled cycle.
module sata_cont_generator_scrambler
    import sata_cont_generator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_reseed,
    output logic [DWORD_W-1:0] o_dword_c
);

    logic [LFSR_W-1:0]  r_lfsr;
    logic [LFSR_W-1:0]  w_lfsr_nxt;
    logic [DWORD_W-1:0] w_dword;

    // Unroll 32 serial shifts; bit i of the dword is the i-th generated bit.
    always_comb begin
        logic [LFSR_W-1:0] v_s;
        v_s     = r_lfsr;
        w_dword = '0;
        for (int i = 0; i < int'(DWORD_W); i++) begin
            w_dword[i] = v_s[0] ^ v_s[2] ^ v_s[11] ^ v_s[15];
            v_s        = {v_s[LFSR_W-2:0], w_dword[i]};
        end
        w_lfsr_nxt = v_s;
    end

    // LFSR state: reseed has priority, otherwise step only when a junk dword is consumed.
    always_ff @(posedge clk) begin
        if (rst || i_reseed) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_en) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign o_dword_c = w_dword;

endmodule

// File: rtl/sata_cont_generator.sv
// Registered TX stage that collapses repeated primitives into CONT followed by junk dwords.
module sata_cont_generator
    import sata_cont_generator_pkg::*;
#(
    parameter int unsigned MIN_REPEAT = 2
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               phy_ready,
    input  logic [DWORD_W-1:0] din,
    input  logic               din_is_k,
    output logic [DWORD_W-1:0] dout,
    output logic               dout_is_k,
    output logic               cont_active
);

    localparam int unsigned      CNT_W   = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_REPEAT);

    localparam logic [0:0] ST_PASS = 1'b0;
    localparam logic [0:0] ST_JUNK = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DWORD_W-1:0] r_last;
    logic [DWORD_W-1:0] w_last_nxt;
    sata_dword_t        w_out_nxt;
    logic               w_cont_nxt;
    logic               w_junk_out;
    logic               w_rep;
    logic               w_match;
    logic               w_scr_en;
    logic               w_scr_reseed;
    logic [DWORD_W-1:0] w_junk;

    assign w_rep   = prim_is_repeatable(din, din_is_k);
    assign w_match = w_rep && (din == r_last);

    // Next state, repeat bookkeeping and next output dword.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_out_nxt   = '{data: din, is_k: din_is_k};
        w_cont_nxt  = 1'b0;
        w_junk_out  = 1'b0;
        if (!en) begin
            w_state_nxt = ST_PASS;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_PASS: begin
                    if (w_match) begin
                        if (r_cnt == CNT_MAX) begin
                            w_out_nxt   = '{data: PRIM_CONT, is_k: 1'b1};
                            w_state_nxt = ST_JUNK;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else if (w_rep) begin
                        w_cnt_nxt  = CNT_W'(1);
                        w_last_nxt = din;
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                ST_JUNK: begin
                    if (w_match) begin
                        w_out_nxt  = '{data: w_junk, is_k: 1'b0};
                        w_cont_nxt = 1'b1;
                        w_junk_out = 1'b1;
                    end else begin
                        w_state_nxt = ST_PASS;
                        if (w_rep) begin
                            w_cnt_nxt  = CNT_W'(1);
                            w_last_nxt = din;
                        end else begin
                            w_cnt_nxt = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_PASS;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and output registers; everything freezes while the phy inserts ALIGN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PASS;
            r_cnt       <= '0;
            r_last      <= PRIM_SYNC;
            dout        <= PRIM_SYNC;
            dout_is_k   <= 1'b1;
            cont_active <= 1'b0;
        end else if (phy_ready) begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            dout        <= w_out_nxt.data;
            dout_is_k   <= w_out_nxt.is_k;
            cont_active <= w_cont_nxt;
        end
    end

    assign w_scr_en     = phy_ready && w_junk_out;
    assign w_scr_reseed = phy_ready && (w_state_nxt == ST_PASS);

    sata_cont_generator_scrambler u_junk_scr (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_scr_en),
        .i_reseed  (w_scr_reseed),
        .o_dword_c (w_junk)
    );

endmodule

// File: tb/tb_sata_cont_generator.sv
// Directed scenarios plus randomized traffic against a sequence-level CONT/junk reference model.
module tb_sata_cont_generator;
    import sata_cont_generator_pkg::*;

    localparam int unsigned MINR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        phy_ready;
    logic [31:0] din;
    logic        din_is_k;
    logic [31:0] dout;
    logic        dout_is_k;
    logic        cont_active;

    int n_checks = 0;
    int n_fail   = 0;
    int ca_cnt;
    int cont_cnt;
    int sof_cnt;
    logic [31:0] seq [$];

    logic [31:0] rep_list [11] = '{32'hB5B5_957C, 32'h5757_B57C, 32'h4A4A_957C, 32'h5555_B57C,
                                   32'h3535_B57C, 32'h5656_B57C, 32'h5858_B57C, 32'hD5D5_AA7C,
                                   32'h9595_AA7C, 32'h1717_B57C, 32'h7575_957C};

    // reference model state
    logic [31:0] m_dout;
    logic        m_isk;
    logic        m_ca;
    logic        m_junk;
    int          m_run;
    logic [31:0] m_last;
    bit          m_hist [16];

    always #5 clk = ~clk;

    sata_cont_generator #(.MIN_REPEAT(MINR)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .phy_ready   (phy_ready),
        .din         (din),
        .din_is_k    (din_is_k),
        .dout        (dout),
        .dout_is_k   (dout_is_k),
        .cont_active (cont_active)
    );

    function automatic bit is_rep(input logic [31:0] d, input logic k);
        bit r = 0;
        if (k) for (int i = 0; i < 11; i++) if (rep_list[i] == d) r = 1;
        return r;
    endfunction

    // Junk bit stream restarts as sixteen ones.
    task automatic m_reseed();
        for (int i = 0; i < 16; i++) m_hist[i] = 1'b1;
    endtask

    // y[n] = y[n-1] ^ y[n-3] ^ y[n-12] ^ y[n-16]; m_hist[15] is the newest bit.
    task automatic m_next_junk(output logic [31:0] w);
        bit y;
        for (int i = 0; i < 32; i++) begin
            y = m_hist[15] ^ m_hist[13] ^ m_hist[4] ^ m_hist[0];
            for (int j = 0; j < 15; j++) m_hist[j] = m_hist[j+1];
            m_hist[15] = y;
            w[i] = y;
        end
    endtask

    task automatic m_reset();
        m_dout = PRIM_SYNC; m_isk = 1'b1; m_ca = 1'b0;
        m_junk = 1'b0; m_run = 0; m_last = PRIM_SYNC;
        m_reseed();
    endtask

    task automatic m_update(input logic [31:0] d, input logic k, input logic e, input logic r);
        bit rep, match;
        logic [31:0] w;
        if (!r) return;
        if (!e) begin
            m_dout = d; m_isk = k; m_ca = 1'b0; m_junk = 1'b0; m_run = 0;
            m_reseed();
            return;
        end
        rep   = is_rep(d, k);
        match = rep && (d == m_last);
        if (m_junk) begin
            if (match) begin
                m_next_junk(w);
                m_dout = w; m_isk = 1'b0; m_ca = 1'b1;
            end else begin
                m_junk = 1'b0; m_dout = d; m_isk = k; m_ca = 1'b0;
                m_reseed();
                if (rep) begin m_run = 1; m_last = d; end else m_run = 0;
            end
        end else begin
            m_ca = 1'b0;
            if (match && m_run == int'(MINR)) begin
                m_dout = PRIM_CONT; m_isk = 1'b1; m_junk = 1'b1;
            end else begin
                m_dout = d; m_isk = k;
                if (match) m_run = (m_run + 1 > int'(MINR)) ? int'(MINR) : m_run + 1;
                else if (rep) begin m_run = 1; m_last = d; end
                else m_run = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge.
    task automatic step(input logic [31:0] d, input logic k, input logic e,
                        input logic r, input logic rs, input string tag);
        @(negedge clk);
        din = d; din_is_k = k; en = e; phy_ready = r; rst = rs;
        @(posedge clk);
        #1;
        if (rs) m_reset(); else m_update(d, k, e, r);
        chk({tag, ".dout"}, dout, m_dout);
        chk({tag, ".is_k"}, 32'(dout_is_k), 32'(m_isk));
        chk({tag, ".cont_active"}, 32'(cont_active), 32'(m_ca));
        if (cont_active) ca_cnt++;
        if (dout === PRIM_CONT && dout_is_k) cont_cnt++;
        if (dout === PRIM_SOF && dout_is_k) sof_cnt++;
        seq.push_back(dout);
    endtask

    task automatic clr();
        ca_cnt = 0; cont_cnt = 0; sof_cnt = 0; seq.delete();
    endtask

    initial begin
        logic [31:0] cur_d;
        logic        cur_k;
        logic [31:0] junk0;
        int unsigned sel;

        rst = 1'b1; en = 1'b1; phy_ready = 1'b1; din = '0; din_is_k = 1'b0;
        m_reset();

        // reset state
        step(PRIM_HOLD, 1'b1, 1'b1, 1'b1, 1'b1, "reset");
        chk("reset_dout", dout, PRIM_SYNC);
        chk("reset_ca", 32'(cont_active), 32'd0);

        // 10 HOLD then data
        clr();
        for (int i = 0; i < 10; i++) step(PRIM_HOLD, 1'b1, 1'b1, 1'b1, 1'b0, "hold10");
        step(32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b0, "hold10_data");
        chk("hold10_seq0", seq[0], PRIM_HOLD);
        chk("hold10_seq1", seq[1], PRIM_HOLD);
        chk("hold10_seq2", seq[2], PRIM_CONT);
        m_reseed(); m_next_junk(junk0); m_reseed();
        chk("hold10_junk0", seq[3], junk0);
        chk("hold10_data_out", seq[10], 32'h1234_5678);
        chk("hold10_ca_cycles", 32'(ca_cnt), 32'd7);

        // SYNC, SYNC, X_RDY: no CONT
        clr();
        step(PRIM_SYNC, 1'b1, 1'b1, 1'b1, 1'b0, "sync_xrdy");
        step(PRIM_SYNC, 1'b1, 1'b1, 1'b1, 1'b0, "sync_xrdy");
        step(PRIM_X_RDY, 1'b1, 1'b1, 1'b1, 1'b0, "sync_xrdy");
        chk("sync_xrdy_nocont", 32'(cont_cnt), 32'd0);
        chk("sync_xrdy_last", seq[2], PRIM_X_RDY);

        // 6 HOLD with phy_ready low on cycles 3-4, plus a stall mid-junk
        clr();
        for (int i = 1; i <= 6; i++)
            step(PRIM_HOLD, 1'b1, 1'b1, (i == 3 || i == 4) ? 1'b0 : 1'b1, 1'b0, "hold_stall");
        step(32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, "hold_stall_junk");
        for (int i = 0; i < 3; i++) step(PRIM_HOLD, 1'b1, 1'b1, 1'b1, 1'b0, "hold_stall_junk");
        chk("hold_stall_frozen", seq[3], seq[2]);
        chk("hold_stall_cont", seq[4], PRIM_CONT);
        chk("hold_stall_junk0", seq[5], junk0);
        step(32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0, "hold_stall_exit");

        // 20 SOF never suppressed
        clr();
        for (int i = 0; i < 20; i++) step(PRIM_SOF, 1'b1, 1'b1, 1'b1, 1'b0, "sof20");
        chk("sof20_count", 32'(sof_cnt), 32'd20);
        chk("sof20_nocont", 32'(cont_cnt), 32'd0);

        // reset while in JUNK
        clr();
        for (int i = 0; i < 5; i++) step(PRIM_HOLD, 1'b1, 1'b1, 1'b1, 1'b0, "rst_junk");
        chk("rst_junk_active", 32'(cont_active), 32'd1);
        step(PRIM_HOLD, 1'b1, 1'b1, 1'b1, 1'b1, "rst_junk_pulse");
        chk("rst_junk_sync", dout, PRIM_SYNC);
        chk("rst_junk_ca", 32'(cont_active), 32'd0);
        clr();
        for (int i = 0; i < 5; i++) step(PRIM_SYNC, 1'b1, 1'b1, 1'b1, 1'b0, "rst_sync5");
        chk("rst_sync5_cont", seq[2], PRIM_CONT);
        chk("rst_sync5_junk0", seq[3], junk0);

        // en=0 pass-through, then enable mid-stream, then drop en during junk
        clr();
        for (int i = 0; i < 8; i++) step(PRIM_R_IP, 1'b1, 1'b0, 1'b1, 1'b0, "en0_rip");
        chk("en0_nocont", 32'(cont_cnt), 32'd0);
        clr();
        for (int i = 0; i < 4; i++) step(PRIM_R_IP, 1'b1, 1'b1, 1'b1, 1'b0, "en1_rip");
        chk("en1_rip_out1", seq[1], PRIM_R_IP);
        chk("en1_rip_cont", seq[2], PRIM_CONT);
        step(PRIM_R_IP, 1'b1, 1'b0, 1'b1, 1'b0, "en_fall_junk");
        chk("en_fall_pass", dout, PRIM_R_IP);
        chk("en_fall_ca", 32'(cont_active), 32'd0);

        // randomized traffic with stalls, enable drops and occasional reset
        cur_d = PRIM_HOLD; cur_k = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                sel = $urandom_range(0, 17);
                if (sel < 11)       begin cur_d = rep_list[sel]; cur_k = 1'b1; end
                else if (sel == 11) begin cur_d = PRIM_SOF;      cur_k = 1'b1; end
                else if (sel == 12) begin cur_d = PRIM_EOF;      cur_k = 1'b1; end
                else if (sel == 13) begin cur_d = PRIM_ALIGN;    cur_k = 1'b1; end
                else if (sel == 14) begin cur_d = PRIM_CONT;     cur_k = 1'b1; end
                else if (sel == 15) begin cur_d = PRIM_HOLD;     cur_k = 1'b0; end
                else                begin cur_d = $urandom;      cur_k = 1'b0; end
            end
            if ($urandom_range(0, 9) == 0)
                step($urandom, 1'($urandom), 1'($urandom), 1'b0, 1'b0, "rand_stall");
            else
                step(cur_d, cur_k, ($urandom_range(0, 19) != 0), 1'b1,
                     ($urandom_range(0, 199) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
